// File: rtl/partselect_ctrl_pkg.sv
// Shared types and defaults for the const_partselect sweep sequencer.
// pack_res fixes the result layout so it matches the datapath wrapper's out_flat.
package partselect_ctrl_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_IDX_W  = 4;
   localparam int unsigned DEF_RES_W  = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_WAIT,
      S_DONE
   } state_e;

   typedef struct packed {
      logic [3:0] sel1;
      logic [2:0] sel2;
      logic       ovf;
   } res_t;

   function automatic logic [DEF_RES_W-1:0] pack_res(input logic [3:0] sel1,
                                                     input logic [2:0] sel2,
                                                     input logic       ovf);
      res_t r;
      r.sel1 = sel1;
      r.sel2 = sel2;
      r.ovf  = ovf;
      return r;
   endfunction

endpackage

// File: rtl/psweep_idx_counter.sv
// Loadable wrap-around sweep index with terminal compare against the latched end index.
module psweep_idx_counter #(
   parameter int unsigned IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             inc,
   input  logic [IDX_W-1:0] load_val,
   input  logic [IDX_W-1:0] end_val,
   output logic [IDX_W-1:0] idx,
   output logic             is_last_c
);

   logic [IDX_W-1:0] end_q;

   // Natural overflow of idx gives the modulo-2**IDX_W wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx   <= '0;
         end_q <= '0;
      end else if (load) begin
         idx   <= load_val;
         end_q <= end_val;
      end else if (inc) begin
         idx   <= idx + IDX_W'(1);
      end
   end

   assign is_last_c = (idx == end_q);

endmodule

// File: rtl/partselect_sweep_ctrl.sv
// Sequencer for the external const_partselect datapath: sweeps idx over a job's
// range, registers each packed result and streams it out on a valid/ready port.
module partselect_sweep_ctrl
   import partselect_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned IDX_W  = DEF_IDX_W,
   parameter int unsigned RES_W  = DEF_RES_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [DATA_W-1:0] job_data1,
   input  logic [DATA_W-1:0] job_data2,
   input  logic [IDX_W-1:0]  job_idx_start,
   input  logic [IDX_W-1:0]  job_idx_end,
   input  logic              abort,
   output logic [DATA_W-1:0] ps_data1,
   output logic [DATA_W-1:0] ps_data2,
   output logic [IDX_W-1:0]  ps_idx,
   input  logic [3:0]        ps_sel1,
   input  logic [2:0]        ps_sel2,
   input  logic              ps_ovf,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [IDX_W-1:0]  res_idx,
   output logic [RES_W-1:0]  res_flat,
   output logic              res_last,
   output logic [IDX_W:0]    ovf_count,
   output logic              done
);

   localparam logic [IDX_W:0] OVF_MAX = {1'b1, {IDX_W{1'b0}}};

   state_e state_q, state_d;
   logic   job_take;
   logic   step_cap;
   logic   res_hs;
   logic   abort_hit;
   logic   cnt_inc;
   logic   is_last_c;

   psweep_idx_counter #(.IDX_W(IDX_W)) u_idx_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (job_take),
      .inc       (cnt_inc),
      .load_val  (job_idx_start),
      .end_val   (job_idx_end),
      .idx       (ps_idx),
      .is_last_c (is_last_c)
   );

   // Next-state and per-cycle strobes; abort overrides any transition out of RUN/WAIT.
   always_comb begin
      state_d   = state_q;
      job_take  = 1'b0;
      step_cap  = 1'b0;
      res_hs    = 1'b0;
      abort_hit = 1'b0;
      cnt_inc   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (job_valid && job_ready) begin
               job_take = 1'b1;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               abort_hit = 1'b1;
               state_d   = S_IDLE;
            end else begin
               step_cap = 1'b1;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            res_hs = res_valid && res_ready;
            if (abort) begin
               abort_hit = 1'b1;
               state_d   = S_IDLE;
            end else if (res_hs) begin
               if (res_last) begin
                  state_d = S_DONE;
               end else begin
                  cnt_inc = 1'b1;
                  state_d = S_RUN;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         job_ready <= 1'b0;
         done      <= 1'b0;
         ps_data1  <= '0;
         ps_data2  <= '0;
         res_valid <= 1'b0;
         res_idx   <= '0;
         res_flat  <= '0;
         res_last  <= 1'b0;
         ovf_count <= '0;
      end else begin
         state_q   <= state_d;
         job_ready <= (state_d == S_IDLE);
         done      <= (state_d == S_DONE);
         if (job_take) begin
            ps_data1  <= job_data1;
            ps_data2  <= job_data2;
            ovf_count <= '0;
         end
         if (abort_hit) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
         end else if (step_cap) begin
            res_flat  <= RES_W'(pack_res(ps_sel1, ps_sel2, ps_ovf));
            res_idx   <= ps_idx;
            res_last  <= is_last_c;
            res_valid <= 1'b1;
            if (ps_ovf && (ovf_count != OVF_MAX)) begin
               ovf_count <= ovf_count + (IDX_W+1)'(1);
            end
         end else if (res_hs) begin
            res_valid <= 1'b0;
         end
      end
   end

   // A job never has more than 2**IDX_W steps, so saturation must never engage.
   ovf_never_saturates: assert property (@(posedge clk) disable iff (!rst_n)
      !(step_cap && ps_ovf && (ovf_count == OVF_MAX)));

endmodule

// File: tb/tb_partselect_sweep_ctrl.sv
// Self-checking bench for partselect_sweep_ctrl with a behavioural datapath stub
// and a job-level reference model of the expected result stream.
module tb_partselect_sweep_ctrl;

   localparam int unsigned DW = 8;
   localparam int unsigned IW = 4;
   localparam int unsigned RW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          job_valid;
   logic          job_ready;
   logic [DW-1:0] job_data1, job_data2;
   logic [IW-1:0] job_idx_start, job_idx_end;
   logic          abort;
   logic [DW-1:0] ps_data1, ps_data2;
   logic [IW-1:0] ps_idx;
   logic [3:0]    ps_sel1;
   logic [2:0]    ps_sel2;
   logic          ps_ovf;
   logic          res_valid, res_ready;
   logic [IW-1:0] res_idx;
   logic [RW-1:0] res_flat;
   logic          res_last;
   logic [IW:0]   ovf_count;
   logic          done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   partselect_sweep_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_data1(job_data1), .job_data2(job_data2),
      .job_idx_start(job_idx_start), .job_idx_end(job_idx_end),
      .abort(abort),
      .ps_data1(ps_data1), .ps_data2(ps_data2), .ps_idx(ps_idx),
      .ps_sel1(ps_sel1), .ps_sel2(ps_sel2), .ps_ovf(ps_ovf),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_idx(res_idx), .res_flat(res_flat), .res_last(res_last),
      .ovf_count(ovf_count), .done(done)
   );

   // Datapath stand-in: arbitrary idx-dependent selects, overflow for idx >= 12.
   function automatic logic [RW-1:0] dp_ref(input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                            input logic [IW-1:0] idx);
      logic [3:0] s1;
      logic [2:0] s2;
      logic       o;
      s1 = 4'(d1 >> idx[2:0]);
      s2 = 3'(d2 >> idx[1:0]) ^ idx[2:0];
      o  = (idx >= 4'd12);
      return {s1, s2, o};
   endfunction

   always_comb {ps_sel1, ps_sel2, ps_ovf} = dp_ref(ps_data1, ps_data2, ps_idx);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Offers one job, then consumes and checks the whole result stream against the model.
   task automatic run_job(input logic [7:0] d1, input logic [7:0] d2,
                          input logic [3:0] s, input logic [3:0] e,
                          input int bp_pct, input int abort_at, input bit stall5, input bit poke);
      int            n, k, stall, exp_ovf;
      logic [IW-1:0] idx;
      bit            ok, hs;
      n = int'(4'(e - s)) + 1;
      @(negedge clk);
      job_valid = 1'b1; job_data1 = d1; job_data2 = d2;
      job_idx_start = s; job_idx_end = e;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (job_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("job_accept", 32'(ok), 32'd1);
      if (!ok) begin job_valid = 1'b0; return; end
      @(negedge clk);
      job_valid = 1'b0;
      check("ovf_clear", 32'(ovf_count), 32'd0);
      check("ps_data1", 32'(ps_data1), 32'(d1));
      check("ps_data2", 32'(ps_data2), 32'(d2));
      check("ps_idx_start", 32'(ps_idx), 32'(s));
      k = 0; exp_ovf = 0; stall = 0;
      for (int cyc = 0; cyc < 400 && k < n; cyc++) begin
         idx = 4'(s + 4'(k));
         res_ready = ($urandom_range(99) >= bp_pct);
         if (poke) job_valid = 1'($urandom_range(1));
         check("job_ready_busy", 32'(job_ready), 32'd0);
         if (res_valid) begin
            if (stall5 && k == 1 && stall < 5) begin res_ready = 1'b0; stall++; end
            check("res_idx", 32'(res_idx), 32'(idx));
            check("res_flat", 32'(res_flat), 32'(dp_ref(d1, d2, idx)));
            check("res_last", 32'(res_last), 32'(k == n - 1));
            check("ps_idx", 32'(ps_idx), 32'(idx));
            if (k == abort_at) begin
               abort = 1'b1; res_ready = 1'b0; job_valid = 1'b0;
               if (idx >= 4'd12) exp_ovf++;
               @(negedge clk);
               abort = 1'b0;
               check("abort_valid", 32'(res_valid), 32'd0);
               check("abort_last", 32'(res_last), 32'd0);
               check("abort_done", 32'(done), 32'd0);
               check("abort_idle", 32'(job_ready), 32'd1);
               check("abort_ovf", 32'(ovf_count), 32'(exp_ovf));
               @(negedge clk);
               check("abort_no_done", 32'(done), 32'd0);
               return;
            end
         end
         hs = res_valid && res_ready;
         @(negedge clk);
         if (hs) begin
            if (idx >= 4'd12) exp_ovf++;
            k++;
         end
      end
      job_valid = 1'b0;
      res_ready = 1'b0;
      check("sweep_complete", 32'(k), 32'(n));
      check("done_pulse", 32'(done), 32'd1);
      check("done_valid_low", 32'(res_valid), 32'd0);
      check("done_ovf", 32'(ovf_count), 32'(exp_ovf));
      check("done_ps_idx", 32'(ps_idx), 32'(e));
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_ready", 32'(job_ready), 32'd1);
      check("idle_ovf_hold", 32'(ovf_count), 32'(exp_ovf));
   endtask

   initial begin
      rst_n = 1'b0; job_valid = 1'b0; job_data1 = '0; job_data2 = '0;
      job_idx_start = '0; job_idx_end = '0; abort = 1'b0; res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(job_ready), 32'd0);
      check("rst_valid", 32'(res_valid), 32'd0);
      check("rst_ovf", 32'(ovf_count), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(job_ready), 32'd1);

      run_job(8'hA5, 8'h3C, 4'd2, 4'd5, 0, -1, 1'b0, 1'b0);
      run_job(8'h96, 8'h71, 4'd14, 4'd1, 0, -1, 1'b0, 1'b0);
      run_job(8'h0F, 8'hE2, 4'd7, 4'd7, 0, -1, 1'b0, 1'b0);
      run_job(8'h5B, 8'hC4, 4'd1, 4'd6, 0, -1, 1'b1, 1'b1);
      run_job(8'h33, 8'h99, 4'd10, 4'd13, 0, -1, 1'b0, 1'b0);
      run_job(8'h12, 8'h34, 4'd0, 4'd9, 0, 1, 1'b0, 1'b0);
      run_job(8'h7E, 8'h81, 4'd3, 4'd3, 0, -1, 1'b0, 1'b0);
      run_job(8'hC0, 8'h0C, 4'd9, 4'd15, 30, 3, 1'b0, 1'b1);
      for (int j = 0; j < 8; j++) begin
         run_job(8'($urandom), 8'($urandom), 4'($urandom_range(15)), 4'($urandom_range(15)),
                 40, -1, 1'b0, 1'b1);
      end

      // Asynchronous reset between edges in the middle of a sweep.
      @(negedge clk);
      job_valid = 1'b1; job_data1 = 8'h5A; job_data2 = 8'hC3;
      job_idx_start = 4'd11; job_idx_end = 4'd9;
      @(negedge clk);
      job_valid = 1'b0; res_ready = 1'b1;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_ready", 32'(job_ready), 32'd0);
      check("arst_valid", 32'(res_valid), 32'd0);
      check("arst_flat", 32'(res_flat), 32'd0);
      check("arst_res_idx", 32'(res_idx), 32'd0);
      check("arst_last", 32'(res_last), 32'd0);
      check("arst_ps_idx", 32'(ps_idx), 32'd0);
      check("arst_ps_data", 32'({ps_data1, ps_data2}), 32'd0);
      check("arst_ovf", 32'(ovf_count), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; res_ready = 1'b0;
      @(negedge clk);
      check("arst_release_ready", 32'(job_ready), 32'd1);
      check("arst_release_valid", 32'(res_valid), 32'd0);
      run_job(8'hA5, 8'h3C, 4'd12, 4'd15, 0, -1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
